// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional funct legality check is enabled by defining ALU_SHARE_OPCHK_EN.
module alu_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*SEL_W-1:0]  req_sel,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SEL_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_g;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic                r_err;

  logic                w_win;
  logic                w_accept;
  logic                w_bad;
  logic [SEL_W-1:0]    w_sel;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_win = 1'b0;
    case (req_valid)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_grant;
      default: w_win = 1'b0;
    endcase
  end

  assign w_accept  = (r_state == S_IDLE) && (|req_valid);
  assign req_ready = w_accept ? (2'b01 << w_win) : 2'b00;
  assign w_sel     = w_win ? req_sel[2*SEL_W-1:SEL_W]   : req_sel[SEL_W-1:0];
  assign w_a       = w_win ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
  assign w_b       = w_win ? req_b[2*DATA_W-1:DATA_W]   : req_b[DATA_W-1:0];

`ifdef ALU_SHARE_OPCHK_EN
  function automatic logic op_supported(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(6'b100000)) || (s == SEL_W'(6'b100010)) ||
           (s == SEL_W'(6'b100100)) || (s == SEL_W'(6'b100101)) ||
           (s == SEL_W'(6'b000000)) || (s == SEL_W'(6'b000010)) ||
           (s == SEL_W'(6'b101010)) || (s == SEL_W'(6'b101011));
  endfunction
  assign w_bad = ~op_supported(w_sel);
`else
  assign w_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_g          <= 1'b0;
      r_sel        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_g   <= w_win;
            r_err <= w_bad;
            if (w_bad) begin
              // Illegal funct bypasses the ALU; its input bus keeps the previous operation.
              r_result <= '0;
              r_zero   <= 1'b0;
              r_state  <= S_RESP;
            end else begin
              r_sel   <= w_sel;
              r_a     <= w_a;
              r_b     <= w_b;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_result <= alu_out;
          r_zero   <= alu_zero;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[r_g]) begin
            r_last_grant <= r_g;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (r_state == S_RESP) ? (2'b01 << r_g) : 2'b00;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_sel    = r_sel;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table plus round-robin, backpressure and reset sequences.
module tb_alu_share_ctrl;
  localparam int DW = 32;
  localparam int SW = 6;

  logic          clk;
  logic          reset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*SW-1:0] req_sel;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_err;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_ctrl #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Reference ALU the controller drives
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      6'b100000: alu_out = alu_a + alu_b;
      6'b100010: alu_out = alu_a - alu_b;
      6'b100100: alu_out = alu_a & alu_b;
      6'b100101: alu_out = alu_a | alu_b;
      6'b000000: alu_out = alu_a << alu_b[4:0];
      6'b000010: alu_out = alu_a >> alu_b[4:0];
      6'b101010: alu_out = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      6'b101011: alu_out = {{(DW-1){1'b0}}, (alu_a < alu_b)};
      default:   alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  typedef struct {
    string       name;
    logic        who;
    logic [5:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  function automatic vec_t mk(input string n, input logic w, input logic [5:0] s,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic z);
    vec_t v;
    v.name = n; v.who = w; v.sel = s; v.a = a; v.b = b; v.res = r; v.zero = z;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = mk("add",      1'b0, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0);
    vecs[1] = mk("sub_zero", 1'b1, 6'b100010, 32'd9,        32'd9,        32'd0,        1'b1);
    vecs[2] = mk("and",      1'b0, 6'b100100, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0);
    vecs[3] = mk("or",       1'b1, 6'b100101, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0);
    vecs[4] = mk("sll31",    1'b1, 6'b000000, 32'd1,        32'd31,       32'h80000000, 1'b0);
    vecs[5] = mk("srl4",     1'b0, 6'b000010, 32'h80000000, 32'd4,        32'h08000000, 1'b0);
    vecs[6] = mk("slt",      1'b1, 6'b101010, 32'd3,        32'd4,        32'd1,        1'b0);
    vecs[7] = mk("slt_neg",  1'b0, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0);
    vecs[8] = mk("sltu",     1'b0, 6'b101011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1);
    vecs[9] = mk("add_wrap", 1'b1, 6'b100000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1);

    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready",  64'(req_ready),  64'h0);
    check("reset rsp_valid",  64'(rsp_valid),  64'h0);
    check("reset rsp_result", 64'(rsp_result), 64'h0);
    check("reset rsp_zero",   64'(rsp_zero),   64'h0);
    check("reset rsp_err",    64'(rsp_err),    64'h0);
    check("reset alu_a",      64'(alu_a),      64'h0);
    check("reset alu_sel",    64'(alu_sel),    64'h0);
    reset_n = 1'b1;
    tick();

    // Single-requester vectors: accept at cycle 0, EXEC at 1, response at 2
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].who ? 2'b10 : 2'b01;
      req_sel   = vecs[i].who ? {vecs[i].sel, 6'b0}  : {6'b0, vecs[i].sel};
      req_a     = vecs[i].who ? {vecs[i].a, 32'd0}   : {32'd0, vecs[i].a};
      req_b     = vecs[i].who ? {vecs[i].b, 32'd0}   : {32'd0, vecs[i].b};
      #1;
      check({vecs[i].name, " req_ready"}, 64'(req_ready), vecs[i].who ? 64'h2 : 64'h1);
      tick();
      req_valid = 2'b00;
      #1;
      check({vecs[i].name, " exec alu_sel"}, 64'(alu_sel), 64'(vecs[i].sel));
      check({vecs[i].name, " exec alu_a"},   64'(alu_a),   64'(vecs[i].a));
      check({vecs[i].name, " exec alu_b"},   64'(alu_b),   64'(vecs[i].b));
      check({vecs[i].name, " exec rsp_valid"}, 64'(rsp_valid), 64'h0);
      tick();
      check({vecs[i].name, " rsp_valid"},  64'(rsp_valid),  vecs[i].who ? 64'h2 : 64'h1);
      check({vecs[i].name, " rsp_result"}, 64'(rsp_result), 64'(vecs[i].res));
      check({vecs[i].name, " rsp_zero"},   64'(rsp_zero),   64'(vecs[i].zero));
      check({vecs[i].name, " rsp_err"},    64'(rsp_err),    64'h0);
      rsp_ready = vecs[i].who ? 2'b10 : 2'b01;
      tick();
      rsp_ready = 2'b00;
      check({vecs[i].name, " rsp_valid after consume"}, 64'(rsp_valid), 64'h0);
    end

    // Tie round-robin with both requesters always valid and rsp_ready held high
    do_reset();
    req_valid = 2'b11;
    req_sel   = {6'b101010, 6'b100010};
    req_a     = {32'd3, 32'd9};
    req_b     = {32'd4, 32'd9};
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d req_ready", k), 64'(req_ready), k[0] ? 64'h2 : 64'h1);
      tick();
      check($sformatf("rr%0d exec req_ready", k), 64'(req_ready), 64'h0);
      check($sformatf("rr%0d exec alu_sel", k), 64'(alu_sel), k[0] ? 64'h2A : 64'h22);
      tick();
      check($sformatf("rr%0d rsp_valid", k), 64'(rsp_valid), k[0] ? 64'h2 : 64'h1);
      check($sformatf("rr%0d rsp_result", k), 64'(rsp_result), k[0] ? 64'h1 : 64'h0);
      check($sformatf("rr%0d rsp_zero", k), 64'(rsp_zero), k[0] ? 64'h0 : 64'h1);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Backpressure: requester 0 held in RESP, rsp_ready[1] must be ignored, requester 1 waits
    req_valid = 2'b11;
    req_sel   = {6'b000000, 6'b100000};
    req_a     = {32'd1, 32'd5};
    req_b     = {32'd31, 32'd7};
    rsp_ready = 2'b10;
    #1;
    check("bp req_ready", 64'(req_ready), 64'h1);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d rsp_valid", c),  64'(rsp_valid),  64'h1);
      check($sformatf("bp hold%0d rsp_result", c), 64'(rsp_result), 64'd12);
      check($sformatf("bp hold%0d req_ready", c),  64'(req_ready),  64'h0);
      tick();
    end
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1;
    check("bp consume rsp_valid", 64'(rsp_valid), 64'h1);
    tick();
    check("bp next req_ready", 64'(req_ready), 64'h2);
    check("bp idle rsp_valid", 64'(rsp_valid), 64'h0);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    check("bp r1 alu_sel", 64'(alu_sel), 64'h0);
    check("bp r1 alu_b",   64'(alu_b),   64'd31);
    tick();
    check("bp r1 rsp_valid",  64'(rsp_valid),  64'h2);
    check("bp r1 rsp_result", 64'(rsp_result), 64'h80000000);
    check("bp r1 rsp_zero",   64'(rsp_zero),   64'h0);
    tick();
    check("bp r1 consumed", 64'(rsp_valid), 64'h0);
    rsp_ready = 2'b00;

    // Reset while a response is held discards it
    req_valid = 2'b10;
    req_sel   = {6'b100101, 6'b000000};
    req_a     = {32'h0000F000, 32'd0};
    req_b     = {32'h0000000F, 32'd0};
    tick();
    req_valid = 2'b00;
    tick();
    check("mid rsp_valid before reset", 64'(rsp_valid), 64'h2);
    reset_n = 1'b0;
    #1;
    check("mid reset rsp_valid",  64'(rsp_valid),  64'h0);
    check("mid reset rsp_result", 64'(rsp_result), 64'h0);
    check("mid reset alu_a",      64'(alu_a),      64'h0);
    check("mid reset alu_b",      64'(alu_b),      64'h0);
    check("mid reset alu_sel",    64'(alu_sel),    64'h0);
    check("mid reset req_ready",  64'(req_ready),  64'h0);
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post reset%0d rsp_valid", c), 64'(rsp_valid), 64'h0);
    end
    req_valid = 2'b11;
    #1;
    check("post reset first tie", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    tick();
    do_reset();

`ifdef ALU_SHARE_OPCHK_EN
    // Unsupported funct goes straight to RESP with rsp_err set and the ALU bus untouched
    req_valid = 2'b01;
    req_sel   = {6'b0, 6'b111111};
    req_a     = {32'd0, 32'd3};
    req_b     = {32'd0, 32'd4};
    #1;
    check("err req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check("err rsp_valid",  64'(rsp_valid),  64'h1);
    check("err rsp_err",    64'(rsp_err),    64'h1);
    check("err rsp_result", 64'(rsp_result), 64'h0);
    check("err alu_sel",    64'(alu_sel),    64'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_sel   = {6'b0, 6'b100000};
    req_a     = {32'd0, 32'd5};
    req_b     = {32'd0, 32'd7};
    tick();
    req_valid = 2'b00;
    tick();
    check("err clear rsp_err",    64'(rsp_err),    64'h0);
    check("err clear rsp_result", 64'(rsp_result), 64'd12);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
